// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : text_pkg
//  Description : Shared constants for the 100x38 character-cell text buffer:
//                geometry, address/char widths, blank glyph code, arbiter
//                state encoding and row/col -> linear address conversion.
//                Also used by the video text renderer.
//  Build macro : TEXT_ARB_ROWCOL_EN widens ADDR_W to 13 so that requesters
//                can present {row[5:0], col[6:0]} addresses.
//  Revision    : 1.0  initial release
// ============================================================================
package text_pkg;

  localparam int COLS  = 100;
  localparam int ROWS  = 38;
  localparam int CELLS = COLS * ROWS;

`ifdef TEXT_ARB_ROWCOL_EN
  localparam int ADDR_W = 13;
`else
  localparam int ADDR_W = 12;
`endif

  localparam int CHAR_W = 8;
  localparam logic [CHAR_W-1:0] BLANK_CODE = 8'd63;

  // Field widths of a {row, col} cell address
  localparam int ROW_W = 6;
  localparam int COL_W = 7;

  // Arbiter FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // row*COLS + col for COLS = 100, built as row*64 + row*32 + row*4 + col so
  // no multiplier is inferred. The 13-bit result covers the full 6/7-bit
  // field range (max 63*100 + 127 = 6427).
  function automatic logic [ROW_W+COL_W-1:0] rowcol_to_linear(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col
  );
    logic [ROW_W+COL_W-1:0] r;
    r = {{COL_W{1'b0}}, row};
    return (r << 6) + (r << 5) + (r << 2) + {{ROW_W{1'b0}}, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : N-way round-robin arbiter. The grant is combinational from
//                valid and the internal priority pointer; the pointer moves to
//                the slot after the granted one when 'advance' is pulsed.
//  Ports       : clk, reset (async, active-high)
//                valid[N]   - request vector
//                advance    - grant was consumed, rotate priority
//                grant[N]   - one-hot grant (all 0 when nothing valid)
//                grant_idx  - binary index of the granted requester
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     valid,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Scan from ptr upward, wrapping modulo N; first valid slot wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      idx = sum[IDX_W-1:0];
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(N-1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/text_buffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer_arbiter
//  Description : Shares the single text-buffer write port among N_REQ
//                requesters with round-robin valid/ready arbitration, and
//                provides a clear-screen sequencer that writes BLANK_CODE to
//                every cell. Writes appear one cycle after the handshake.
//  Build macro : TEXT_ARB_ROWCOL_EN - req_addr fields are {row, col} and are
//                converted to a linear address; otherwise req_addr is linear.
//  Ports       : clk, reset (async, active-high)
//                req_valid/req_ready[N_REQ]  - per-requester handshake
//                req_addr[N_REQ*ADDR_W]      - packed cell addresses
//                req_char[N_REQ*CHAR_W]      - packed character codes
//                clear_start                 - pulse: start screen clear
//                clear_busy                  - clear in progress
//                clear_done                  - pulse after the last clear write
//                mem_we/mem_addr/mem_wdata   - text buffer write port
//                oob_err                     - pulse: accepted address invalid
//  Revision    : 1.0  initial release
// ============================================================================
module text_buffer_arbiter
  import text_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*CHAR_W-1:0] req_char,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    clear_done,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [CHAR_W-1:0]       mem_wdata,
  output logic                    oob_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CELLS - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;

  logic              arb_en;
  logic [N_REQ-1:0]  arb_valid;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              hs;

  logic [ADDR_W-1:0] sel_addr;
  logic [CHAR_W-1:0] sel_char;
  logic [ADDR_W-1:0] lin_addr;
  logic              addr_oob;

  // Requests are only visible to the arbiter in IDLE when no clear is being
  // launched. Reset is included so req_ready reads 0 while reset is held.
  assign arb_en    = !reset && (state == ST_IDLE) && !clear_start;
  assign arb_valid = req_valid & {N_REQ{arb_en}};

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .valid     (arb_valid),
    .advance   (hs),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign hs        = |grant;

  // One-hot select of the granted requester's address and character
  always_comb begin
    sel_addr = '0;
    sel_char = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_char = req_char[i*CHAR_W +: CHAR_W];
      end
    end
  end

`ifdef TEXT_ARB_ROWCOL_EN
  logic [ROW_W-1:0] sel_row;
  logic [COL_W-1:0] sel_col;

  assign sel_row  = sel_addr[ROW_W+COL_W-1:COL_W];
  assign sel_col  = sel_addr[COL_W-1:0];
  assign lin_addr = ADDR_W'(rowcol_to_linear(sel_row, sel_col));
  assign addr_oob = (sel_col >= COL_W'(COLS)) || (sel_row >= ROW_W'(ROWS));
`else
  assign lin_addr = sel_addr;
  assign addr_oob = (sel_addr >= ADDR_W'(CELLS));
`endif

  // clr_cnt always equals the address being presented on mem_addr during a
  // clear, so the terminal test and the next address come from one register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      oob_err    <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      oob_err    <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state      <= ST_CLEAR;
            clear_busy <= 1'b1;
            clr_cnt    <= '0;
            mem_we     <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= BLANK_CODE;
          end else if (hs) begin
            if (addr_oob) begin
              oob_err <= 1'b1;
            end else begin
              mem_we    <= 1'b1;
              mem_addr  <= lin_addr;
              mem_wdata <= sel_char;
            end
          end
        end
        ST_CLEAR: begin
          // clear_start is deliberately ignored here
          if (clr_cnt == CLR_LAST) begin
            state      <= ST_IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
            clr_cnt    <= '0;
          end else begin
            clr_cnt   <= clr_cnt + 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= clr_cnt + 1'b1;
            mem_wdata <= BLANK_CODE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_text_buffer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_buffer_arbiter
//  Description : Scoreboard bench for text_buffer_arbiter. Stimulus pushes the
//                expected write-port event (kind, cycle, address, data) into a
//                queue; a negedge monitor pops and compares whenever mem_we,
//                oob_err or clear_done is high. Grants are checked directly.
//  Build macro : TEXT_ARB_ROWCOL_EN adds the row/col address vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_text_buffer_arbiter;
  import text_pkg::*;

  localparam int N      = 3;
  localparam int K_WR   = 0;
  localparam int K_OOB  = 1;
  localparam int K_DONE = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N*ADDR_W-1:0] req_addr;
  logic [N*CHAR_W-1:0] req_char;
  logic                clear_start;
  logic                clear_busy;
  logic                clear_done;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [CHAR_W-1:0]   mem_wdata;
  logic                oob_err;

  logic [ADDR_W-1:0] ta [N];
  logic [CHAR_W-1:0] tc [N];
  int                tl [N];

  assign req_addr = {ta[2], ta[1], ta[0]};
  assign req_char = {tc[2], tc[1], tc[0]};

  text_buffer_arbiter #(.N_REQ(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_char    (req_char),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .oob_err     (oob_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int cyc;
    int addr;
    int data;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] pack_ev(input int kind, input int c, input int a, input int d);
    return {16'd0, 8'(kind), 16'(c), 16'(a), 8'(d)};
  endfunction

  task automatic push(input int kind, input int c, input int a, input int d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [ADDR_W-1:0] enc(input int lin);
`ifdef TEXT_ARB_ROWCOL_EN
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
    r = ROW_W'(lin / COLS);
    c = COL_W'(lin % COLS);
    return {r, c};
`else
    return ADDR_W'(lin);
`endif
  endfunction

  task automatic set_lin(input int i, input int lin, input int ch);
    tl[i] = lin;
    ta[i] = enc(lin);
    tc[i] = CHAR_W'(ch);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request cycle, check the grant, and queue the resulting event.
  task automatic req_cycle(input logic [N-1:0] v, input logic [N-1:0] exp_rdy, input string name);
    int g;
    req_valid = v;
    @(negedge clk);
    chk(name, 64'(req_ready), 64'(exp_rdy));
    g = -1;
    for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
    if (g >= 0) begin
      if (tl[g] >= CELLS) push(K_OOB, cyc + 1, 0, 0);
      else                push(K_WR, cyc + 1, tl[g], int'(tc[g]));
    end
    tick();
  endtask

  // Monitor
  int          m_kind;
  logic [63:0] m_act;
  ev_t         m_ev;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      chk("missing_event", 64'(cyc), 64'(exp_q[0].cyc));
      void'(exp_q.pop_front());
    end
    if (mem_we || oob_err || clear_done) begin
      m_kind = mem_we ? K_WR : (oob_err ? K_OOB : K_DONE);
      m_act  = pack_ev(m_kind, cyc, mem_we ? int'(mem_addr) : 0, mem_we ? int'(mem_wdata) : 0);
      chk("exclusive_outputs", 64'($countones({mem_we, oob_err, clear_done})), 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", m_act, 64'd0);
      end else begin
        m_ev = exp_q.pop_front();
        chk("mem_event", m_act, pack_ev(m_ev.kind, m_ev.cyc, m_ev.addr, m_ev.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  int c0;

  initial begin
    reset       = 1'b1;
    clear_start = 1'b0;
    for (int i = 0; i < N; i++) set_lin(i, 0, 0);
    set_lin(0, 1846, 57);
    req_valid = 3'b001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        64'({req_ready, clear_busy, clear_done, mem_we, oob_err, mem_addr, mem_wdata}), 64'd0);
    tick();
    reset = 1'b0;

    // Single write, then an idle cycle
    req_cycle(3'b001, 3'b001, "single_write_grant");
    req_cycle(3'b000, 3'b000, "idle_no_grant");

    // Requester 2 alone: pointer returns to 0
    set_lin(2, 500, 66);
    req_cycle(3'b100, 3'b100, "r2_only_grant");

    // Fairness: all valid for 6 cycles, boundary addresses 0 and 3799
    set_lin(0, 10, 65);
    set_lin(1, 3799, 66);
    set_lin(2, 0, 67);
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] e;
      e = N'(1 << (k % 3));
      req_cycle(3'b111, e, "fair_grant");
    end

    // Out of range on requester 1, pointer then sits at 2
    set_lin(1, 3800, 99);
    req_cycle(3'b010, 3'b010, "oob_grant");
    set_lin(2, 3000, 70);
    req_cycle(3'b111, 3'b100, "ptr_after_oob");
    set_lin(1, 1234, 71);
    req_cycle(3'b110, 3'b010, "skip_invalid");
    req_cycle(3'b011, 3'b001, "wrap_grant");

`ifdef TEXT_ARB_ROWCOL_EN
    ta[0] = {6'd19, 7'd46};
    tl[0] = 1946;
    tc[0] = 8'd72;
    req_cycle(3'b001, 3'b001, "rowcol_write");
    ta[0] = {6'd19, 7'd100};
    tl[0] = 9999;
    req_cycle(3'b001, 3'b001, "rowcol_col_oob");
`endif
    req_cycle(3'b000, 3'b000, "gap_idle");

    // Clear with requester 2 pending; pointer is 1 so r2 wins afterwards
    set_lin(2, 123, 90);
    req_valid   = 3'b100;
    clear_start = 1'b1;
    @(negedge clk);
    chk("clear_start_blocks_ready", 64'(req_ready), 64'd0);
    c0 = cyc;
    for (int a = 0; a < CELLS; a++) push(K_WR, c0 + 1 + a, a, int'(BLANK_CODE));
    push(K_DONE, c0 + CELLS + 1, 0, 0);
    tick();
    for (int i = 1; i <= CELLS; i++) begin
      clear_start = (i == 500);
      @(negedge clk);
      if (i == 1 || i == 500 || i == CELLS) begin
        chk("busy_in_clear", 64'(clear_busy), 64'd1);
        chk("ready_in_clear", 64'(req_ready), 64'd0);
      end
      tick();
    end
    clear_start = 1'b0;
    req_cycle(3'b100, 3'b100, "pending_after_clear");
    req_cycle(3'b000, 3'b000, "post_clear_idle");

    // Reset in the middle of a clear
    clear_start = 1'b1;
    @(negedge clk);
    c0 = cyc;
    for (int a = 0; a < 1000; a++) push(K_WR, c0 + 1 + a, a, int'(BLANK_CODE));
    tick();
    clear_start = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_clear_reset",
        64'({req_ready, clear_busy, clear_done, mem_we, oob_err, mem_addr, mem_wdata}), 64'd0);
    tick();
    reset = 1'b0;

    // Fresh clear starts at address 0
    clear_start = 1'b1;
    @(negedge clk);
    c0 = cyc;
    for (int a = 0; a < CELLS; a++) push(K_WR, c0 + 1 + a, a, int'(BLANK_CODE));
    push(K_DONE, c0 + CELLS + 1, 0, 0);
    tick();
    clear_start = 1'b0;
    repeat (CELLS + 2) tick();

    repeat (3) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
